// File: rtl/matvec_param.sv
// matvec_param: streaming y = W*x engine for an NxN signed matrix and an N-element vector.
// Operands arrive one word per cycle (matrix row-major, then vector); N row results leave
// in order. A single serial MAC with one registered multiplier stage computes each row.
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous active-low reset
//   input_valid   input word valid
//   input_ready   block can accept a word
//   input_data    signed matrix or vector word
//   new_matrix    sampled with the first word: 1 = N*N matrix words precede the vector
//   output_valid  output_data holds a row result
//   output_ready  consumer accepts output_data
//   output_data   signed result y[row]
module matvec_param #(
   parameter int unsigned N     = 8,
   parameter int unsigned IN_W  = 14,
   parameter int unsigned OUT_W = 2 * IN_W + $clog2(N),
   parameter bit          SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             input_valid,
   output logic             input_ready,
   input  logic [IN_W-1:0]  input_data,
   input  logic             new_matrix,
   output logic             output_valid,
   input  logic             output_ready,
   output logic [OUT_W-1:0] output_data
);

   localparam int unsigned AccW  = 2 * IN_W + $clog2(N);
   localparam int unsigned AddrW = $clog2(N * N);
   localparam int unsigned IdxW  = $clog2(N);
   localparam int unsigned CntW  = $clog2(N + 2);

   typedef enum logic [2:0] {StIdle, StLoadW, StLoadX, StCompute, StOutput} state_e;

   state_e                   state_q, state_d;
   logic [AddrW-1:0]         widx_q, widx_d;
   logic [IdxW-1:0]          xidx_q, xidx_d;
   logic [IdxW-1:0]          row_q, row_d;
   logic [CntW-1:0]          cnt_q, cnt_d;
   logic signed [2*IN_W-1:0] prod_q, prod_d;
   logic signed [AccW-1:0]   acc_q, acc_d, prod_ext;
   logic [OUT_W-1:0]         out_q, out_d, acc_conv;
   logic                     loaded_q, loaded_d;

   logic                     in_fire;
   logic                     w_we, x_we;
   logic [AddrW-1:0]         w_waddr, rd_addr;
   logic [IdxW-1:0]          x_waddr;
   logic signed [IN_W-1:0]   w_rd, x_rd;

   logic signed [IN_W-1:0]   w_mem [N*N];
   logic signed [IN_W-1:0]   x_mem [N];

   // Writes are gated by reset so words offered during reset are never stored.
   assign in_fire      = input_valid & input_ready & reset;
   assign input_ready  = (state_q == StIdle) | (state_q == StLoadW) | (state_q == StLoadX);
   assign output_valid = (state_q == StOutput);
   assign output_data  = out_q;

   assign rd_addr  = AddrW'(row_q) * AddrW'(N) + AddrW'(cnt_q);
   assign w_rd     = w_mem[rd_addr];
   assign x_rd     = x_mem[cnt_q[IdxW-1:0]];
   assign prod_ext = {{(AccW - 2 * IN_W){prod_q[2*IN_W-1]}}, prod_q};

   // Final accumulator to output width.
   if (OUT_W >= AccW) begin : g_sext
      assign acc_conv = OUT_W'(acc_q);
   end else if (SAT) begin : g_sat
      logic [AccW-OUT_W:0] hi;
      assign hi       = acc_q[AccW-1:OUT_W-1];
      // Fits when every bit above the output sign bit matches it.
      assign acc_conv = ((&hi) | ~(|hi)) ? acc_q[OUT_W-1:0] :
                        (acc_q[AccW-1] ? {1'b1, {(OUT_W - 1){1'b0}}} :
                                         {1'b0, {(OUT_W - 1){1'b1}}});
   end else begin : g_wrap
      assign acc_conv = acc_q[OUT_W-1:0];
   end

   always_comb begin
      state_d  = state_q;
      widx_d   = widx_q;
      xidx_d   = xidx_q;
      row_d    = row_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      acc_d    = acc_q;
      out_d    = out_q;
      loaded_d = loaded_q;
      w_we     = 1'b0;
      x_we     = 1'b0;
      w_waddr  = widx_q;
      x_waddr  = xidx_q;
      unique case (state_q)
         StIdle: begin
            if (in_fire) begin
               if (new_matrix || !loaded_q) begin
                  w_we     = 1'b1;
                  w_waddr  = '0;
                  widx_d   = AddrW'(1);
                  // The resident matrix is being overwritten; it is valid again only
                  // once the full load completes.
                  loaded_d = 1'b0;
                  state_d  = StLoadW;
               end else begin
                  x_we    = 1'b1;
                  x_waddr = '0;
                  xidx_d  = IdxW'(1);
                  state_d = StLoadX;
               end
            end
         end
         StLoadW: begin
            if (in_fire) begin
               w_we = 1'b1;
               if (widx_q == AddrW'(N * N - 1)) begin
                  loaded_d = 1'b1;
                  widx_d   = '0;
                  xidx_d   = '0;
                  state_d  = StLoadX;
               end else begin
                  widx_d = widx_q + AddrW'(1);
               end
            end
         end
         StLoadX: begin
            if (in_fire) begin
               x_we = 1'b1;
               if (xidx_q == IdxW'(N - 1)) begin
                  xidx_d  = '0;
                  row_d   = '0;
                  cnt_d   = '0;
                  acc_d   = '0;
                  state_d = StCompute;
               end else begin
                  xidx_d = xidx_q + IdxW'(1);
               end
            end
         end
         StCompute: begin
            cnt_d = cnt_q + CntW'(1);
            // Multiply issues on cnt 0..N-1; accumulate trails by one cycle (cnt 1..N).
            if (cnt_q < CntW'(N)) begin
               prod_d = w_rd * x_rd;
            end
            if ((cnt_q != '0) && (cnt_q <= CntW'(N))) begin
               acc_d = acc_q + prod_ext;
            end
            if (cnt_q == CntW'(N + 1)) begin
               out_d   = acc_conv;
               state_d = StOutput;
            end
         end
         StOutput: begin
            if (output_ready) begin
               if (row_q == IdxW'(N - 1)) begin
                  state_d = StIdle;
               end else begin
                  row_d   = row_q + IdxW'(1);
                  cnt_d   = '0;
                  acc_d   = '0;
                  state_d = StCompute;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         widx_q   <= '0;
         xidx_q   <= '0;
         row_q    <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
         acc_q    <= '0;
         out_q    <= '0;
         loaded_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         widx_q   <= widx_d;
         xidx_q   <= xidx_d;
         row_q    <= row_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         acc_q    <= acc_d;
         out_q    <= out_d;
         loaded_q <= loaded_d;
      end
   end

   // Operand storage is not reset.
   always_ff @(posedge clk) begin
      if (w_we) begin
         w_mem[w_waddr] <= input_data;
      end
      if (x_we) begin
         x_mem[x_waddr] <= input_data;
      end
   end

endmodule

// File: tb/tb_matvec_param.sv
// Directed bench for matvec_param: an N=8/IN_W=14 instance (wrap, sign-extend path) and an
// N=4/IN_W=8/OUT_W=16 saturating instance share one stimulus bus selected by sel4.
module tb_matvec_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel4;
   logic        in_vld, in_nm, out_rdy;
   logic [13:0] in_data;

   logic        rdy8, vld8, rdy4, vld4;
   logic [30:0] out8;
   logic [15:0] out4;

   logic        in_rdy, out_vld;
   int          out_s;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   int wv [64];
   int xv [8];
   int ev [8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   matvec_param u_dut8 (
      .clk          (clk),
      .reset        (reset),
      .input_valid  (in_vld & ~sel4),
      .input_ready  (rdy8),
      .input_data   (in_data),
      .new_matrix   (in_nm),
      .output_valid (vld8),
      .output_ready (out_rdy & ~sel4),
      .output_data  (out8)
   );

   matvec_param #(
      .N     (4),
      .IN_W  (8),
      .OUT_W (16),
      .SAT   (1'b1)
   ) u_dut4 (
      .clk          (clk),
      .reset        (reset),
      .input_valid  (in_vld & sel4),
      .input_ready  (rdy4),
      .input_data   (in_data[7:0]),
      .new_matrix   (in_nm),
      .output_valid (vld4),
      .output_ready (out_rdy & sel4),
      .output_data  (out4)
   );

   always_comb begin
      if (sel4) begin
         in_rdy  = rdy4;
         out_vld = vld4;
         out_s   = $signed(out4);
      end else begin
         in_rdy  = rdy8;
         out_vld = vld8;
         out_s   = $signed(out8);
      end
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_word(input int d, input logic nm);
      int guard = 0;
      int dv    = d;
      in_data = dv[13:0];
      in_nm   = nm;
      in_vld  = 1'b1;
      while (!in_rdy && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) check_eq("send_timeout", 0, 1);
      @(negedge clk);
      in_vld = 1'b0;
      in_nm  = 1'b0;
   endtask

   // nw matrix words from wv then nx vector words from xv; nm rides on the first word.
   // A 3-cycle valid gap is inserted before word gap_at (no gap when negative).
   task automatic run_txn(input logic nm, input int nw, input int nx, input int gap_at);
      for (int i = 0; i < nw + nx; i++) begin
         if (i == gap_at) begin
            in_vld = 1'b0;
            repeat (3) @(negedge clk);
         end
         send_word((i < nw) ? wv[i] : xv[i-nw], (i == 0) ? nm : 1'b0);
      end
   endtask

   task automatic get_row(input string tag, input int expv);
      int guard = 0;
      out_rdy = 1'b1;
      while (!out_vld && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         check_eq({tag, "_timeout"}, 0, 1);
      end else begin
         check_eq(tag, out_s, expv);
         @(negedge clk);
      end
   endtask

   task automatic get_rows(input string tag, input int n);
      for (int r = 0; r < n; r++) get_row($sformatf("%s_row%0d", tag, r), ev[r]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c0;
      int guard;

      // 1: reset held with valid asserted.
      sel4    = 1'b0;
      reset   = 1'b0;
      in_vld  = 1'b1;
      in_nm   = 1'b1;
      in_data = 14'h0155;
      out_rdy = 1'b0;
      repeat (2) @(negedge clk);
      in_vld = 1'b0;
      reset  = 1'b1;
      @(negedge clk);
      check_eq("rst_rdy8", int'(rdy8), 1);
      check_eq("rst_vld8", int'(vld8), 0);
      check_eq("rst_out8", int'(out8), 0);
      check_eq("rst_rdy4", int'(rdy4), 1);
      check_eq("rst_vld4", int'(vld4), 0);
      check_eq("rst_out4", int'(out4), 0);

      // 2: identity load with a mid-load stall, x = 1..8, latency check.
      for (int i = 0; i < 64; i++) wv[i] = (i / 8 == i % 8) ? 1 : 0;
      for (int j = 0; j < 8; j++) begin
         xv[j] = j + 1;
         ev[j] = j + 1;
      end
      run_txn(1'b1, 64, 8, 20);
      c0    = cyc;
      guard = 0;
      out_rdy = 1'b1;
      while (!vld8 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check_eq("t2_latency", cyc - c0, 10);
      get_rows("t2", 8);

      // 3: reuse the identity with x = -3, then a fresh all-2 matrix with x = 3.
      for (int j = 0; j < 8; j++) begin
         xv[j] = -3;
         ev[j] = -3;
      end
      run_txn(1'b0, 0, 8, -1);
      get_rows("t3a", 8);
      for (int i = 0; i < 64; i++) wv[i] = 2;
      for (int j = 0; j < 8; j++) begin
         xv[j] = 3;
         ev[j] = 48;
      end
      run_txn(1'b1, 64, 8, -1);
      get_rows("t3b", 8);

      // 4: most negative operands, sum 2^29 fits the 31-bit output.
      for (int i = 0; i < 64; i++) wv[i] = -8192;
      for (int j = 0; j < 8; j++) begin
         xv[j] = -8192;
         ev[j] = 536870912;
      end
      run_txn(1'b1, 64, 8, -1);
      get_rows("t4", 8);

      // 5: diagonal (r+1), x = 10..17, backpressure on row 3.
      for (int i = 0; i < 64; i++) wv[i] = (i / 8 == i % 8) ? (i / 8 + 1) : 0;
      for (int j = 0; j < 8; j++) begin
         xv[j] = 10 + j;
         ev[j] = (j + 1) * (10 + j);
      end
      run_txn(1'b1, 64, 8, -1);
      for (int r = 0; r < 3; r++) get_row($sformatf("t5_row%0d", r), ev[r]);
      out_rdy = 1'b0;
      guard   = 0;
      while (!out_vld && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      for (int k = 0; k < 5; k++) begin
         check_eq($sformatf("t5_hold_vld%0d", k), int'(out_vld), 1);
         check_eq($sformatf("t5_hold_data%0d", k), out_s, ev[3]);
         check_eq($sformatf("t5_hold_rdy%0d", k), int'(in_rdy), 0);
         @(negedge clk);
      end
      for (int r = 3; r < 8; r++) get_row($sformatf("t5_row%0d", r), ev[r]);

      // 6: saturating N=4 instance, then reset mid-load forces the next txn to load.
      sel4 = 1'b1;
      for (int i = 0; i < 16; i++) wv[i] = -128;
      for (int j = 0; j < 4; j++) begin
         xv[j] = -128;
         ev[j] = 32767;
      end
      run_txn(1'b1, 16, 4, -1);
      get_rows("t6a", 4);
      for (int i = 0; i < 5; i++) send_word(7, (i == 0) ? 1'b1 : 1'b0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("t6_rst_rdy", int'(in_rdy), 1);
      check_eq("t6_rst_vld", int'(out_vld), 0);
      check_eq("t6_rst_out", out_s, 0);
      for (int i = 0; i < 16; i++) wv[i] = (i / 4 == i % 4) ? 1 : 0;
      for (int j = 0; j < 4; j++) begin
         xv[j] = 5 + j;
         ev[j] = 5 + j;
      end
      run_txn(1'b0, 16, 4, -1);
      get_rows("t6b", 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
